// File: rtl/data_mem_responder_if.sv
// Request/response channel between a load/store initiator and a memory responder.
// Ports: req_* carry one access (valid/ready); rsp_* return load data or an error (valid/ready).
// The master modport is the initiator side; the slave modport is the responder side.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Big-endian byte-addressed data memory answering byte/halfword/word loads and stores.
// Latency: response valid WAIT_CYCLES+1 edges after accept; one transaction in flight.
// Backpressure: response held until rsp_ready; no request accepted until the cycle after.
// Ports: clk, rst_n (async, active-low); bus (slave side of data_mem_responder_if);
//        busy (transaction in progress); dbg_addr/dbg_data (side-effect-free byte peek).
module data_mem_responder #(
  parameter int ADDR_W      = 5,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_mem_responder_if.slave   bus,
  output logic                  busy,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [7:0]            dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q;
  logic                lat_write;
  logic [1:0]          lat_size;
  logic [ADDR_W-1:0]   lat_addr;
  logic [31:0]         lat_wdata;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic                req_ready;
  logic                rsp_valid;

  logic [7:0]          mem [DEPTH];

  // Upper address bits are outside the array and intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W];

  // Byte lanes of the latched access; ADDR_W-bit arithmetic gives modulo-DEPTH wrap.
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  assign a0 = lat_addr;
  assign a1 = lat_addr + ADDR_W'(1);
  assign a2 = lat_addr + ADDR_W'(2);
  assign a3 = lat_addr + ADDR_W'(3);

  logic acc_err;
  assign acc_err = (lat_size == 2'b11)
                 | ((lat_size == 2'b01) & lat_addr[0])
                 | ((lat_size == 2'b10) & (lat_addr[1:0] != 2'b00));

  logic access;
  assign access = (state_q == WAIT) && (cnt_q == 4'd0);

  logic [31:0] acc_rdata;
  always_comb begin
    acc_rdata = '0;
    case (lat_size)
      2'b00:   acc_rdata = {24'h0, mem[a0]};
      2'b01:   acc_rdata = {16'h0, mem[a0], mem[a1]};
      2'b10:   acc_rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
      default: acc_rdata = '0;
    endcase
    // Stores and faulting accesses return zero.
    if (acc_err || lat_write) acc_rdata = '0;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (bus.req_valid) state_d = WAIT;
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lat_write <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (bus.req_valid) begin
          lat_write <= bus.req_write;
          lat_size  <= bus.req_size;
          lat_addr  <= bus.req_addr[ADDR_W-1:0];
          lat_wdata <= bus.req_wdata;
          cnt_q     <= 4'(WAIT_CYCLES);
        end
        WAIT: if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          rdata_q <= acc_rdata;
          err_q   <= acc_err;
        end
        RESP: if (bus.rsp_ready) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The array has no reset; a store lands only on its access edge, and an
  // asynchronous reset forces IDLE so a pending store never reaches it.
  always_ff @(posedge clk) begin
    if (access && lat_write && !acc_err) begin
      case (lat_size)
        2'b00: mem[a0] <= lat_wdata[7:0];
        2'b01: begin
          mem[a0] <= lat_wdata[15:8];
          mem[a1] <= lat_wdata[7:0];
        end
        2'b10: begin
          mem[a0] <= lat_wdata[31:24];
          mem[a1] <= lat_wdata[23:16];
          mem[a2] <= lat_wdata[15:8];
          mem[a3] <= lat_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign dbg_data      = mem[dbg_addr];

endmodule
